// File: rtl/circ_seq_if.sv
// Sample/window bus for circ_seq: stereo write side in, sequenced window out.
// The ovf flag exists only when CIRC_SEQ_OVF_EN is defined.
interface circ_seq_if;
  logic               wrt_smpl;
  logic signed [15:0] lft_smpl;
  logic signed [15:0] rght_smpl;
  logic               sequencing;
  logic signed [15:0] lft_out;
  logic signed [15:0] rght_out;
`ifdef CIRC_SEQ_OVF_EN
  logic               ovf;
`endif

  modport master (
    output wrt_smpl, lft_smpl, rght_smpl,
`ifdef CIRC_SEQ_OVF_EN
    input  ovf,
`endif
    input  sequencing, lft_out, rght_out
  );

  modport slave (
    input  wrt_smpl, lft_smpl, rght_smpl,
`ifdef CIRC_SEQ_OVF_EN
    output ovf,
`endif
    output sequencing, lft_out, rght_out
  );
endinterface

// File: rtl/circ_seq.sv
// Circular stereo sample buffer that streams the last SEQ_LEN samples, oldest first,
// after each qualifying write. Optional sticky overflow flag: define CIRC_SEQ_OVF_EN.
module circ_seq #(
  parameter int DEPTH   = 1536,
  parameter int SEQ_LEN = 1021
) (
  input logic       clk,
  input logic       rst,
  circ_seq_if.slave smp
);
  localparam int DATA_W = 16;
  localparam int AW     = $clog2(DEPTH);
  localparam int FW     = $clog2(SEQ_LEN + 1);
  localparam int CW     = $clog2(SEQ_LEN + 1);

  localparam logic [0:0] IDLE = 1'b0;
  localparam logic [0:0] SEQ  = 1'b1;

  localparam logic [AW-1:0] LAST_ADDR = AW'(DEPTH - 1);
  localparam logic [AW-1:0] A_ONE     = AW'(1);
  localparam logic [AW-1:0] BACK      = AW'(SEQ_LEN - 1);
  localparam logic [AW-1:0] FWD       = AW'(DEPTH - SEQ_LEN + 1);
  localparam logic [FW-1:0] FILL_MAX  = FW'(SEQ_LEN);
  localparam logic [FW-1:0] FILL_TRIG = FW'(SEQ_LEN - 1);
  localparam logic [FW-1:0] FILL_ONE  = FW'(1);
  localparam logic [CW-1:0] CNT_LAST  = CW'(SEQ_LEN - 1);
  localparam logic [CW-1:0] CNT_ONE   = CW'(1);

  function automatic logic [AW-1:0] next_addr(input logic [AW-1:0] a);
    return (a == LAST_ADDR) ? '0 : a + A_ONE;
  endfunction

  logic [2*DATA_W-1:0] mem [DEPTH];
  logic [2*DATA_W-1:0] rdata_q;

  logic [0:0]    state_q, state_d;
  logic [AW-1:0] wptr_q, wptr_d;
  logic [AW-1:0] rptr_q, rptr_d;
  logic [FW-1:0] fill_q, fill_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [AW-1:0] start_addr;
  logic          trig;

  // Oldest window entry sits SEQ_LEN-1 slots behind the slot the trigger sample lands in.
  assign start_addr = (wptr_q >= BACK) ? wptr_q - BACK : wptr_q + FWD;
  assign trig       = (state_q == IDLE) && smp.wrt_smpl && (fill_q >= FILL_TRIG);

  always_comb begin
    state_d = state_q;
    wptr_d  = wptr_q;
    rptr_d  = rptr_q;
    fill_d  = fill_q;
    cnt_d   = cnt_q;
    if (smp.wrt_smpl) begin
      wptr_d = next_addr(wptr_q);
      if (fill_q != FILL_MAX) fill_d = fill_q + FILL_ONE;
    end
    case (state_q)
      IDLE: begin
        if (trig) begin
          state_d = SEQ;
          rptr_d  = next_addr(start_addr);
          cnt_d   = '0;
        end
      end
      default: begin
        rptr_d = next_addr(rptr_q);
        cnt_d  = cnt_q + CNT_ONE;
        if (cnt_q == CNT_LAST) state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      wptr_q  <= '0;
      rptr_q  <= '0;
      fill_q  <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      wptr_q  <= wptr_d;
      rptr_q  <= rptr_d;
      fill_q  <= fill_d;
      cnt_q   <= cnt_d;
    end
  end

  // Sample storage: registered read is launched at the trigger edge so data is ready in cycle 0.
  always_ff @(posedge clk) begin
    if (smp.wrt_smpl) mem[wptr_q] <= {smp.lft_smpl, smp.rght_smpl};
    if (trig || (state_q == SEQ)) rdata_q <= mem[(state_q == IDLE) ? start_addr : rptr_q];
  end

  assign smp.sequencing = (state_q == SEQ);
  assign smp.lft_out    = (state_q == SEQ) ? $signed(rdata_q[2*DATA_W-1:DATA_W]) : '0;
  assign smp.rght_out   = (state_q == SEQ) ? $signed(rdata_q[DATA_W-1:0]) : '0;

`ifdef CIRC_SEQ_OVF_EN
  logic ovf_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) ovf_q <= 1'b0;
    else if (smp.wrt_smpl && (state_q == SEQ)) ovf_q <= 1'b1;
  end

  assign smp.ovf = ovf_q;
`endif
endmodule
